// File: rtl/pulse_req_src.sv
// Source half of a toggle-based pulse synchronizer: counts events, issues one request
// toggle at a time and waits for the synchronized ack. Optional ack timeout: PULSE_REQ_TIMEOUT_EN.
module pulse_req_src #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             src_clk,
    input  logic             src_rstn,
    input  logic             s_event,
    input  logic             ack_toggle,
    input  logic             err_clr,
    output logic             req_toggle,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
            $error("pulse_req_src: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   ack_match;
    logic                   issue;
    logic                   cnt_drop;
    logic                   to_hit;
    logic                   req_nxt;
    logic                   ovf_nxt;
    logic [CNT_W-1:0]       pend_nxt;

    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_toggle};
        end
    end

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ack_match = (ack_s == req_toggle);
    assign issue     = (state == ST_IDLE) && (pend_cnt != '0);

`ifdef PULSE_REQ_TIMEOUT_EN
    localparam int             TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT, so every WAIT visit starts counting from zero.
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            to_cnt <= '0;
        end else if (state != ST_WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (state == ST_WAIT) && !ack_match && (to_cnt == TO_LAST);

    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            timeout_err <= 1'b0;
        end else if (to_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            state      <= ST_IDLE;
            req_toggle <= 1'b0;
            pend_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_toggle <= req_nxt;
            pend_cnt   <= pend_nxt;
            overflow   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = req_toggle;
        pend_nxt  = pend_cnt;
        ovf_nxt   = overflow;
        cnt_drop  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (issue) begin
                    req_nxt   = ~req_toggle;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_match) begin
                    state_nxt = ST_IDLE;
                end else if (to_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // An event arriving on an issue edge replaces the issued one, so the count holds.
        if (s_event && !issue) begin
            if (pend_cnt == CNT_MAX) begin
                cnt_drop = 1'b1;
            end else begin
                pend_nxt = pend_cnt + 1'b1;
            end
        end else if (!s_event && issue) begin
            pend_nxt = pend_cnt - 1'b1;
        end

        if (err_clr) begin
            ovf_nxt = 1'b0;
        end
        if (cnt_drop) begin
            ovf_nxt = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || (pend_cnt != '0);

endmodule

// File: tb/tb_pulse_req_src.sv
// Directed bench for pulse_req_src: default instance plus a CNT_W=2, TIMEOUT_CYC=8 instance
// for saturation and timeout cases.
module tb_pulse_req_src;

    logic       clk;
    logic       rstn;
    logic       s_event, ack, err_clr;
    logic       req, busy, ovf, toerr;
    logic [3:0] pend;

    logic       c_event, c_ack, c_clr;
    logic       c_req, c_busy, c_ovf, c_toerr;
    logic [1:0] c_pend;

    int   n_run = 0;
    int   n_fail = 0;
    int   n_tr = 0;
    int   tr_base = 0;
    logic req_q = 1'b0;

    pulse_req_src dut (
        .src_clk    (clk),
        .src_rstn   (rstn),
        .s_event    (s_event),
        .ack_toggle (ack),
        .err_clr    (err_clr),
        .req_toggle (req),
        .pend_cnt   (pend),
        .busy       (busy),
        .overflow   (ovf),
        .timeout_err(toerr)
    );

    pulse_req_src #(.CNT_W(2), .SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut_c (
        .src_clk    (clk),
        .src_rstn   (rstn),
        .s_event    (c_event),
        .ack_toggle (c_ack),
        .err_clr    (c_clr),
        .req_toggle (c_req),
        .pend_cnt   (c_pend),
        .busy       (c_busy),
        .overflow   (c_ovf),
        .timeout_err(c_toerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req !== req_q) n_tr <= n_tr + 1;
        req_q <= req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Destination model: wait for a new request, then return the ack after d cycles.
    task automatic serve(input int d);
        int k = 0;
        while (req === ack && k < 40) begin
            tick();
            k++;
        end
        check("serve_req_seen", 32'(k < 40), 1);
        repeat (d) tick();
        ack = req;
    endtask

    initial begin
        rstn = 1'b0; s_event = 1'b0; ack = 1'b0; err_clr = 1'b0;
        c_event = 1'b0; c_ack = 1'b0; c_clr = 1'b0;
        repeat (2) tick();
        check("rst_req", 32'(req), 0);
        check("rst_pend", 32'(pend), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_toerr", 32'(toerr), 0);
        rstn = 1'b1;
        tick();

        // single event, ack looped back 3 cycles after the issue
        s_event = 1'b1;
        tick();
        s_event = 1'b0;
        check("one_pend_after_event", 32'(pend), 1);
        check("one_req_not_yet", 32'(req), 0);
        tick();
        check("one_req_toggled", 32'(req), 1);
        check("one_pend_issued", 32'(pend), 0);
        check("one_busy_wait", 32'(busy), 1);
        repeat (3) tick();
        ack = 1'b1;
        repeat (2) tick();
        check("one_busy_until_match", 32'(busy), 1);
        tick();
        check("one_busy_done", 32'(busy), 0);
        check("one_req_final", 32'(req), 1);

        // event coinciding with an issue at pend_cnt=2
        s_event = 1'b1;
        tick();
        check("coin_e1_pend", 32'(pend), 1);
        tick();
        check("coin_e2_pend", 32'(pend), 1);
        check("coin_e2_req", 32'(req), 0);
        tick();
        s_event = 1'b0;
        check("coin_e3_pend", 32'(pend), 2);
        ack = 1'b0;
        repeat (3) tick();
        check("coin_idle_pend", 32'(pend), 2);
        check("coin_idle_req", 32'(req), 0);
        s_event = 1'b1;
        tick();
        s_event = 1'b0;
        check("coin_issue_pend", 32'(pend), 2);
        check("coin_issue_req", 32'(req), 1);
        serve(1);
        serve(1);
        serve(1);
        repeat (3) tick();
        check("coin_drain_busy", 32'(busy), 0);
        check("coin_drain_pend", 32'(pend), 0);
        check("coin_drain_req", 32'(req), 1);

        s_event = 1'b1;
        tick();
        s_event = 1'b0;
        serve(1);
        repeat (3) tick();
        check("flip_req", 32'(req), 0);
        check("flip_busy", 32'(busy), 0);

        // reset asserted mid-WAIT with three events pending
        s_event = 1'b1;
        repeat (4) tick();
        s_event = 1'b0;
        check("rwait_pend", 32'(pend), 3);
        check("rwait_req", 32'(req), 1);
        check("rwait_busy", 32'(busy), 1);
        #2;
        rstn = 1'b0;
        ack = 1'b0;
        #1;
        check("rwait_async_req", 32'(req), 0);
        check("rwait_async_pend", 32'(pend), 0);
        check("rwait_async_busy", 32'(busy), 0);
        check("rwait_async_ovf", 32'(ovf), 0);
        check("rwait_async_toerr", 32'(toerr), 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        tr_base = n_tr;

        // five back-to-back events, each ack returned 6 cycles after its request
        fork
            begin
                s_event = 1'b1;
                repeat (5) tick();
                s_event = 1'b0;
                check("b2b_pend_peak", 32'(pend), 4);
            end
            begin
                repeat (5) serve(6);
            end
        join
        repeat (4) tick();
        check("b2b_transitions", 32'(n_tr - tr_base), 5);
        check("b2b_req_final", 32'(req), 1);
        check("b2b_ovf", 32'(ovf), 0);
        check("b2b_pend_final", 32'(pend), 0);
        check("b2b_busy_final", 32'(busy), 0);

        // CNT_W=2 saturation with the ack held low
        c_event = 1'b1;
        repeat (4) tick();
        check("sat_pend", 32'(c_pend), 3);
        check("sat_ovf_clear", 32'(c_ovf), 0);
        tick();
        check("sat_ovf_set", 32'(c_ovf), 1);
        check("sat_pend_hold", 32'(c_pend), 3);
        c_clr = 1'b1;
        tick();
        check("sat_set_wins", 32'(c_ovf), 1);
        c_event = 1'b0;
        tick();
        c_clr = 1'b0;
        check("sat_ovf_cleared", 32'(c_ovf), 0);
        check("sat_pend_after_clr", 32'(c_pend), 3);
        check("sat_req", 32'(c_req), 1);
        repeat (2) tick();
        check("to_not_yet", 32'(c_toerr), 0);
        tick();
`ifdef PULSE_REQ_TIMEOUT_EN
        check("to_err_set", 32'(c_toerr), 1);
        check("to_busy", 32'(c_busy), 1);
        c_event = 1'b1;
        tick();
        c_event = 1'b0;
        check("to_err_counts_event", 32'(c_ovf), 1);
        check("to_err_pend_hold", 32'(c_pend), 3);
        tick();
        check("to_err_req_hold", 32'(c_req), 1);
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        check("to_clr_err", 32'(c_toerr), 0);
        check("to_clr_ovf", 32'(c_ovf), 0);
        check("to_clr_req", 32'(c_req), 1);
        tick();
        check("to_resume_req", 32'(c_req), 0);
        check("to_resume_pend", 32'(c_pend), 2);
`else
        check("to_disabled_err", 32'(c_toerr), 0);
        check("to_disabled_req", 32'(c_req), 1);
        check("to_disabled_pend", 32'(c_pend), 3);
        repeat (10) tick();
        check("to_disabled_err_late", 32'(c_toerr), 0);
        check("to_disabled_busy", 32'(c_busy), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
